// File: rtl/sea_pkg.sv
// sea_pkg: shared widths, FSM states, mode encodings and rotate helper for the SEA engine
package sea_pkg;
    localparam int SEA_LANE_W = 256;
    localparam int SEA_KEY_W  = 256;
    localparam int SEA_RKEY_W = 128;
    typedef enum logic [2:0] {IDLE, KEYEXP, ENC, DEC, DONE} sea_state_t;
    typedef enum logic {SEA_ENC = 1'b0, SEA_DEC = 1'b1} sea_mode_t;
    function automatic logic [SEA_RKEY_W-1:0] rotl(input logic [SEA_RKEY_W-1:0] x, input int unsigned s);
        return (x << s) | (x >> (SEA_RKEY_W - s));
    endfunction
endpackage

// File: rtl/sea_round_engine_if.sv
// sea_round_engine_if: request/response bus between the system and the SEA engine
interface sea_round_engine_if #(
    parameter int LANES = 1,
    parameter int CNT_W = 16
);
    localparam int DATA_W = 256 * LANES;
    logic              start, ready, mode, out_valid, out_ready, err, busy;
    logic [DATA_W-1:0] data_in, data_out;
    logic [255:0]      key_in;
    logic [CNT_W-1:0]  num_rounds;
    modport master (
        output start, mode, data_in, key_in, num_rounds, out_ready,
        input  ready, out_valid, data_out, err, busy
    );
    modport slave (
        input  start, mode, data_in, key_in, num_rounds, out_ready,
        output ready, out_valid, data_out, err, busy
    );
endinterface

// File: rtl/Decryption.sv
// Decryption: exact inverse of one Encryption round under the same round key
module Decryption import sea_pkg::*; (
    input  logic [SEA_LANE_W-1:0] data_i,
    input  logic [SEA_RKEY_W-1:0] rkey_i,
    output logic [SEA_LANE_W-1:0] data_o
);
    assign data_o = {data_i[SEA_RKEY_W-1:0] ^ rotl(data_i[SEA_LANE_W-1:SEA_RKEY_W] ^ rkey_i, 3),
                     data_i[SEA_LANE_W-1:SEA_RKEY_W]};
endmodule

// File: rtl/Encryption.sv
// Encryption: one Feistel round; right half keyed and rotated into the left half
module Encryption import sea_pkg::*; (
    input  logic [SEA_LANE_W-1:0] data_i,
    input  logic [SEA_RKEY_W-1:0] rkey_i,
    output logic [SEA_LANE_W-1:0] data_o
);
    assign data_o = {data_i[SEA_RKEY_W-1:0],
                     data_i[SEA_LANE_W-1:SEA_RKEY_W] ^ rotl(data_i[SEA_RKEY_W-1:0] ^ rkey_i, 3)};
endmodule

// File: rtl/final_keygen.sv
// final_keygen: next 256-bit schedule key from the current one
module final_keygen import sea_pkg::*; (
    input  logic [SEA_KEY_W-1:0] key_i,
    output logic [SEA_KEY_W-1:0] key_o
);
    assign key_o = {key_i[SEA_RKEY_W-1:0],
                    key_i[SEA_KEY_W-1:SEA_RKEY_W] ^ rotl(key_i[SEA_RKEY_W-1:0], 5) ^ SEA_RKEY_W'(1)};
endmodule

// File: rtl/sea_round_core.sv
// sea_round_core: per-lane encrypt/decrypt rounds plus the shared key-generation step
module sea_round_core import sea_pkg::*; #(
    parameter int LANES = 1
) (
    input  logic [SEA_LANE_W*LANES-1:0] state_i,
    input  logic [SEA_RKEY_W-1:0]       rkey_i,
    input  logic [SEA_KEY_W-1:0]        key_i,
    output logic [SEA_LANE_W*LANES-1:0] enc_o,
    output logic [SEA_LANE_W*LANES-1:0] dec_o,
    output logic [SEA_KEY_W-1:0]        key_o
);
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        Encryption u_enc (.data_i(state_i[i*SEA_LANE_W +: SEA_LANE_W]), .rkey_i(rkey_i),
                          .data_o(enc_o[i*SEA_LANE_W +: SEA_LANE_W]));
        Decryption u_dec (.data_i(state_i[i*SEA_LANE_W +: SEA_LANE_W]), .rkey_i(rkey_i),
                          .data_o(dec_o[i*SEA_LANE_W +: SEA_LANE_W]));
    end
    final_keygen u_kg (.key_i(key_i), .key_o(key_o));
endmodule

// File: rtl/sea_round_engine.sv
// sea_round_engine: iterative multi-lane SEA encrypt/decrypt with round-key store and schedule cache
module sea_round_engine import sea_pkg::*; #(
    parameter int LANES      = 1,
    parameter int MAX_ROUNDS = 64,
    parameter int CNT_W      = 16
) (
    input logic clk,
    input logic reset,
    sea_round_engine_if.slave bus
);
    localparam int DATA_W = SEA_LANE_W * LANES;
    localparam int IDX_W  = $clog2(MAX_ROUNDS);
    sea_state_t state_q, state_d;
    logic [DATA_W-1:0]     st_q, enc, dec;
    logic [SEA_KEY_W-1:0]  k_q, k0_q, k_nxt, cache_key_q;
    logic [SEA_RKEY_W-1:0] store_q [MAX_ROUNDS];
    logic [SEA_RKEY_W-1:0] rkey;
    logic [CNT_W-1:0]      rnd_q, n_q, cache_n_q;
    logic err_q, cache_valid_q, accept, illegal, hit, last, fill;
    assign accept  = bus.start && state_q == IDLE;
    assign illegal = bus.num_rounds == '0 || bus.num_rounds > CNT_W'(MAX_ROUNDS);
    assign hit     = cache_valid_q && bus.key_in == cache_key_q && bus.num_rounds <= cache_n_q;
    // an illegal request spends one cycle in ENC with the datapath frozen
    assign last    = err_q || rnd_q == n_q;
    assign fill    = (state_q == ENC && !err_q) || state_q == KEYEXP;
    assign rkey    = state_q == DEC ? store_q[IDX_W'(n_q - rnd_q)] : k_q[SEA_RKEY_W-1:0];
    sea_round_core #(.LANES(LANES)) u_core (
        .state_i(st_q), .rkey_i(rkey), .key_i(k_q),
        .enc_o(enc), .dec_o(dec), .key_o(k_nxt)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.start) state_d = (illegal || bus.mode == SEA_ENC) ? ENC : hit ? DEC : KEYEXP;
            KEYEXP:   if (last) state_d = DEC;
            ENC, DEC: if (last) state_d = DONE;
            DONE:     if (bus.out_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end
    always_comb begin
        bus.ready     = state_q == IDLE;
        bus.busy      = state_q != IDLE;
        bus.out_valid = state_q == DONE;
        bus.err       = state_q == DONE && err_q;
        bus.data_out  = (state_q == DONE && !err_q) ? st_q : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cache_valid_q <= 1'b0;
        else if (accept && !illegal && bus.mode == SEA_DEC && !hit)
            cache_valid_q <= 1'b0;
        else if (fill && last)
            cache_valid_q <= 1'b1;
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            st_q  <= bus.data_in;
            k_q   <= bus.key_in;
            k0_q  <= bus.key_in;
            n_q   <= bus.num_rounds;
            err_q <= illegal;
            rnd_q <= CNT_W'(1);
        end else if (state_q inside {KEYEXP, ENC, DEC}) begin
            rnd_q <= last ? CNT_W'(1) : rnd_q + CNT_W'(1);
        end
        if (fill) begin
            store_q[IDX_W'(rnd_q - CNT_W'(1))] <= k_q[SEA_RKEY_W-1:0];
            k_q <= k_nxt;
        end
        if (state_q == ENC && !err_q) st_q <= enc;
        if (state_q == DEC) st_q <= dec;
        if (fill && last) begin
            cache_key_q <= k0_q;
            cache_n_q   <= n_q;
        end
    end
endmodule
